// File: rtl/bayer_pattern_gen.sv
// Test-pattern frame generator: XOR, ramp, constant or LFSR pixels with row and frame blanking.
// Define PATTERN_LFSR_EN to build the mode-3 LFSR; without it mode 3 emits zero with identical timing.
module bayer_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK  = 2,
  parameter int V_BLANK  = 20
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iCONT,
  input  logic [1:0]  iMODE,
  input  logic [11:0] iCONST,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic        oBUSY,
  output logic        oFRAME_DONE
);
  localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST  = 11'(V_ACTIVE - 1);
  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t      state;
  logic [15:0] blank_cnt;
  logic [1:0]  mode;
  logic [11:0] const_val;
  logic [11:0] lfsr_cur;
  logic [11:0] start_lfsr;
  logic        frame_start;

  function automatic logic [11:0] pixel(input logic [1:0] m, input logic [11:0] c,
                                        input logic [10:0] x, input logic [10:0] y,
                                        input logic [11:0] lv);
    case (m)
      2'd0:    pixel = {1'b0, x} ^ {1'b0, y};
      2'd1:    pixel = {1'b0, x};
      2'd2:    pixel = c;
      default: pixel = lv;
    endcase
  endfunction

  // A new frame begins from IDLE on a start request, or straight out of the last VBLANK cycle when continuous.
  assign frame_start = ((state == IDLE) && iSTART) ||
                       ((state == VBLANK) && (blank_cnt == VB_LAST) && iCONT);

`ifdef PATTERN_LFSR_EN
  localparam logic [11:0] SEED = 12'hACE;

  logic [11:0] lfsr;
  logic        pixel_adv;

  function automatic logic [11:0] lfsr_step(input logic [11:0] s);
    lfsr_step = {s[10:0], s[11] ^ s[10] ^ s[9] ^ s[3]};
  endfunction

  assign pixel_adv = ((state == ACTIVE) && (oX_Cont != X_LAST)) ||
                     ((state == HBLANK) && (blank_cnt == HB_LAST));

  // lfsr always holds the value for the next valid pixel; the frame's first pixel is the seed itself.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)            lfsr <= SEED;
    else if (frame_start) lfsr <= lfsr_step(SEED);
    else if (pixel_adv)   lfsr <= lfsr_step(lfsr);
  end

  assign lfsr_cur   = lfsr;
  assign start_lfsr = SEED;
`else
  assign lfsr_cur   = 12'h000;
  assign start_lfsr = 12'h000;
`endif

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state       <= IDLE;
      blank_cnt   <= '0;
      mode        <= '0;
      const_val   <= '0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oBUSY       <= 1'b0;
      oFRAME_DONE <= 1'b0;
    end else begin
      oFRAME_DONE <= 1'b0;
      if (frame_start) begin
        state     <= ACTIVE;
        mode      <= iMODE;
        const_val <= iCONST;
        oX_Cont   <= '0;
        oY_Cont   <= '0;
        oDATA     <= pixel(iMODE, iCONST, 11'd0, 11'd0, start_lfsr);
        oDVAL     <= 1'b1;
        oBUSY     <= 1'b1;
      end else begin
        case (state)
          ACTIVE: begin
            if (oX_Cont != X_LAST) begin
              oX_Cont <= oX_Cont + 11'd1;
              oDATA   <= pixel(mode, const_val, oX_Cont + 11'd1, oY_Cont, lfsr_cur);
            end else begin
              oDVAL     <= 1'b0;
              blank_cnt <= '0;
              if (oY_Cont != Y_LAST) begin
                state <= HBLANK;
              end else begin
                state       <= VBLANK;
                oFRAME_DONE <= 1'b1;
              end
            end
          end
          HBLANK: begin
            if (blank_cnt == HB_LAST) begin
              state   <= ACTIVE;
              oX_Cont <= '0;
              oY_Cont <= oY_Cont + 11'd1;
              oDVAL   <= 1'b1;
              oDATA   <= pixel(mode, const_val, 11'd0, oY_Cont + 11'd1, lfsr_cur);
            end else begin
              blank_cnt <= blank_cnt + 16'd1;
            end
          end
          VBLANK: begin
            if (blank_cnt == VB_LAST) begin
              state <= IDLE;
              oBUSY <= 1'b0;
            end else begin
              blank_cnt <= blank_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
